prog_clk_div: RTL
=================

Name: prog_clk_div

Overview:
- Runtime-programmable clock divider and tone source; the parametrised successor of the fixed-period divider.
- Divides clk_100mhz by a divisor loaded at run time through a valid/ready handshake.
- Produces a square wave (clk_out) and a one-cycle period strobe (tick).
- Divisor changes are applied only at period boundaries, so note changes are glitch-free. Sits between the key/score logic and the buzzer/PWM output.

Parameters:
- CNT_W, 32, width of the divisor and the internal counter.
- RESET_DIV, 100000, active divisor after reset; must be 0 or at least 2 and fit in CNT_W bits.

Ports:
- clk_100mhz  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = run, 0 = hold counter and outputs idle.
- restart  input  1  one-cycle request to restart the current period at phase 0.
- div_in  input  CNT_W  new divisor (output period in clk_100mhz cycles); 0 = silence.
- div_valid  input  1  div_in is valid.
- div_ready  output  1  block can accept a divisor.
- clk_out  output  1  divided square wave.
- tick  output  1  one-cycle pulse in the last cycle of each period.
- active_div  output  CNT_W  divisor currently in effect.

Behaviour:
- Reset (rst=1 at posedge): cnt=0, active_div=RESET_DIV, no pending load, clk_out=0, tick=0, div_ready=1.
- Divisor clamp: an accepted div_in of 1 is stored as 2. Value 0 is kept as 0 and means silence.
- Running = enable=1 and active_div=N≥2.
  - Each cycle cnt advances 0,1,…,N-1,0,…
  - clk_out is registered and equals 1 exactly in cycles where cnt < (N>>1).
  - tick is registered and equals 1 exactly in cycles where cnt = N-1.
  - Resulting waveform: high for N>>1 cycles, low for N-(N>>1) cycles, period exactly N cycles. Example: N=5 gives 2 high, 3 low.
- Idle = enable=0 or N=0.
  - cnt held at 0; clk_out=0 and tick=0 from the next cycle.
  - After leaving idle, the first running cycle has cnt=0 and clk_out=1.
- Handshake:
  - A transfer occurs when div_valid and div_ready are both 1 at a posedge; the value is captured into a pending register.
  - div_ready = ~pending. It is registered, so it is 0 in the cycle after acceptance.
  - div_valid without div_ready must be held by the source. The block never drops or overwrites a pending value.
- Apply rules:
  - When running, pending is applied at the period boundary. On the posedge where cnt = N_old-1, active_div takes the pending value, pending clears, and the next cycle is cnt=0 of the new period.
  - When idle, pending is applied on the next posedge.
  - div_ready returns to 1 on the cycle after the apply.
- restart while running: next cycle cnt=0 and clk_out=1. tick is not asserted for the truncated period. A pending divisor is applied at this point.
- Simultaneous events, in priority order:
  - rst is highest.
  - enable=0 overrides restart.
  - restart on the boundary cycle is equivalent to a normal wrap.
  - Load acceptance and apply never coincide, because div_ready=0 whenever pending is set.
- Reset mid-period: everything returns to reset values next cycle and any pending divisor is discarded.
- Counter compare logic is sized CNT_W; no overflow is possible because cnt < N ≤ 2^CNT_W-1.

Test Plan:
- Reset with RESET_DIV=10, enable=1 → clk_out shows 5 high / 5 low, tick pulses every 10 cycles at cnt=9, active_div=10.
- Load div_in=7 at cnt=3 of a 10-cycle period → div_ready drops the next cycle; the current period completes all 10 cycles; the next period is 3 high / 4 low; active_div=7 from the boundary; div_ready=1 one cycle later.
- Back-to-back loads: div_valid held with 4 then 6 → the 6 is not accepted until the 4 is applied; the periods run old, then 4, then 6 in order, with none skipped.
- Load div_in=1 → active_div=2 and clk_out toggles every cycle. Load div_in=0 → clk_out=0, tick=0 while idle, and a following load of 8 applies on the next cycle.
- enable=0 mid-period, then enable=1 → outputs 0 during idle; the first running cycle has cnt=0 and clk_out=1, and a full period follows.
- restart at cnt=6 of a 10-cycle period, and rst asserted mid-period with a pending load → restart gives a new period from phase 0 with no tick; rst restores active_div=RESET_DIV and discards the pending value.

Source files
------------

// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider / tone source: square wave plus end-of-period tick.
// New divisors are taken through a valid/ready port and applied only at a period boundary.
module prog_clk_div #(
  parameter int          CNT_W     = 32,
  parameter int unsigned RESET_DIV = 100000
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] active_div
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic [CNT_W-1:0] pend_div;

  logic             accept;
  logic             go_idle;
  logic             wrap;
  logic             boundary;
  logic [CNT_W-1:0] in_clamped;
  logic [CNT_W-1:0] div_next;
  logic [CNT_W-1:0] cnt_inc;

  // Handshake: a divisor transfers on a posedge where div_valid && div_ready.
  // div_ready is the registered inverse of pending, so the source must hold
  // div_valid/div_in until it sees ready; a pending value is never overwritten.
  always_comb begin
    accept     = div_valid && div_ready;
    in_clamped = (div_in == CNT_W'(1)) ? CNT_W'(2) : div_in;
    go_idle    = !enable || (active_div == '0);
    wrap       = (state == S_RUN) && (cnt == active_div - CNT_W'(1));
    boundary   = (state == S_IDLE) || restart || wrap;
    div_next   = pending ? pend_div : active_div;
    cnt_inc    = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      active_div <= CNT_W'(RESET_DIV);
      pending    <= 1'b0;
      pend_div   <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      div_ready  <= 1'b1;
    end else begin
      if (go_idle) begin
        state   <= S_IDLE;
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (pending) begin
          active_div <= pend_div;
          pending    <= 1'b0;
          div_ready  <= 1'b1;
        end
      end else if (boundary) begin
        // Start of a fresh period: first cycle after idle, restart, or wrap.
        cnt        <= '0;
        tick       <= 1'b0;
        active_div <= div_next;
        pending    <= 1'b0;
        div_ready  <= 1'b1;
        if (div_next == '0) begin
          state   <= S_IDLE;
          clk_out <= 1'b0;
        end else begin
          state   <= S_RUN;
          clk_out <= 1'b1;
        end
      end else begin
        cnt     <= cnt_inc;
        clk_out <= (cnt_inc < (active_div >> 1));
        tick    <= (cnt_inc == active_div - CNT_W'(1));
      end

      // Acceptance only happens with pending clear, so it never collides with an apply.
      if (accept) begin
        pending   <= 1'b1;
        pend_div  <= in_clamped;
        div_ready <= 1'b0;
      end
    end
  end

endmodule
